// File: rtl/mem_pkg.sv
// mem_pkg -- shared definitions for the data memory controller.
//   * RISC-V funct3 width/sign codes used by loads and stores
//   * controller FSM state encoding (IDLE / WAIT / RESP)
//   * helpers for funct3 legality, load lane extraction/extension and
//     store byte-enable / data-lane replication
package mem_pkg;

   // funct3 width/sign codes
   localparam logic [2:0] F3_BYTE   = 3'b000;  // LB / SB
   localparam logic [2:0] F3_HALF   = 3'b001;  // LH / SH
   localparam logic [2:0] F3_WORD   = 3'b010;  // LW / SW
   localparam logic [2:0] F3_BYTE_U = 3'b100;  // LBU
   localparam logic [2:0] F3_HALF_U = 3'b101;  // LHU

   // FSM state enumeration, kept as plain constants for legacy tools
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_RESP = 2'd2;

   // Loads accept B/H/W/BU/HU, stores only B/H/W.
   function automatic logic f3_legal(input logic write, input logic [2:0] f3);
      if (write)
         return (f3 == F3_BYTE) || (f3 == F3_HALF) || (f3 == F3_WORD);
      return (f3 == F3_BYTE) || (f3 == F3_HALF) || (f3 == F3_WORD) ||
             (f3 == F3_BYTE_U) || (f3 == F3_HALF_U);
   endfunction

   // Pick the addressed lane out of the stored word and extend it.
   // Halfword lane uses off[1] only, so a misaligned halfword simply
   // reads the aligned halfword that contains it.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_BYTE:   return {{24{b[7]}}, b};
         F3_HALF:   return {{16{h[15]}}, h};
         F3_WORD:   return word;
         F3_BYTE_U: return {24'd0, b};
         F3_HALF_U: return {16'd0, h};
         default:   return 32'd0;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_BYTE: return 4'b0001 << off;
         F3_HALF: return off[1] ? 4'b1100 : 4'b0011;
         F3_WORD: return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // Right-aligned store data replicated onto every lane; the byte
   // enables decide which copy actually lands.
   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
      case (f3)
         F3_BYTE: return {4{wdata[7:0]}};
         F3_HALF: return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

endpackage

// File: rtl/data_ram.sv
// data_ram -- DEPTH x 32 single-port RAM, synchronous registered read,
// per-byte write enables. Contents are never initialised or reset.
// Ports:
//   clk_i  clock
//   re     read enable (rdata updates on the next rising edge)
//   we     write enable, qualified per byte by be
//   be     4-bit byte enable
//   addr   word index
//   wdata  write data (lane-aligned)
//   rdata  registered read data, holds its value while re is low
module data_ram #(
   parameter int DEPTH = 1024
) (
   input  logic                     clk_i,
   input  logic                     re,
   input  logic                     we,
   input  logic [3:0]               be,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);

   // One byte-wide array per lane keeps every lane a clean inferred RAM.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q_reg;

      always_ff @(posedge clk_i) begin
         if (we && be[gi])
            mem[addr] <= wdata[gi*8 +: 8];
         if (re)
            q_reg <= mem[addr];
      end

      assign rdata[gi*8 +: 8] = q_reg;
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl -- load/store controller in front of a byte-enabled data RAM.
// One request outstanding at most; IDLE accepts, WAIT spends WAIT_STATES
// cycles and performs the RAM access on its last cycle, RESP holds the
// response until the core takes it.
// Optional feature: define MISALIGN_CHECK_EN to reject misaligned
// halfword/word accesses with an error instead of ignoring the low bits.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_valid_i/ready_o   request handshake
//   req_write_i           1 = store, 0 = load
//   req_funct3_i          RISC-V width/sign code
//   req_addr_i            byte address (wraps modulo 4*MEM_DEPTH_WORDS)
//   req_wdata_i           right-aligned store data
//   rsp_valid_o/ready_i   response handshake
//   rsp_rdata_o           extended load data, 0 for stores and errors
//   rsp_err_o             request rejected, no memory side effect
module data_mem_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int MEM_DEPTH_WORDS = 1024,
   parameter int WAIT_STATES     = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_write_i,
   input  logic [2:0]            req_funct3_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [31:0]           req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [31:0]           rsp_rdata_o,
   output logic                  rsp_err_o
);

   localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);
   localparam int CNT_W = $clog2(WAIT_STATES + 1);

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             write_reg;
   logic [2:0]       f3_reg;
   logic [IDX_W+1:0] addr_reg;   // word index plus byte offset
   logic [31:0]      wdata_reg;
   logic             err_reg;

   logic             misalign;
   logic             req_err;
   logic             ram_fire;
   logic [31:0]      ram_q;

   // Address bits above the memory span wrap away.
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr_i[ADDR_WIDTH-1:IDX_W+2];

`ifdef MISALIGN_CHECK_EN
   // funct3[1:0]==01 is a halfword (signed or unsigned)
   assign misalign = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                     ((req_funct3_i == F3_WORD) && (req_addr_i[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign req_err = !f3_legal(req_write_i, req_funct3_i) || misalign;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         write_reg <= 1'b0;
         f3_reg    <= 3'd0;
         addr_reg  <= '0;
         wdata_reg <= 32'd0;
         err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (req_valid_i) begin
                  write_reg <= req_write_i;
                  f3_reg    <= req_funct3_i;
                  addr_reg  <= req_addr_i[IDX_W+1:0];
                  wdata_reg <= req_wdata_i;
                  err_reg   <= req_err;
                  cnt_reg   <= CNT_W'(WAIT_STATES - 1);
                  state_reg <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_reg == '0)
                  state_reg <= ST_RESP;
               else
                  cnt_reg <= cnt_reg - CNT_W'(1);
            end
            ST_RESP: begin
               if (rsp_ready_i)
                  state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // The RAM access happens on the edge that leaves WAIT, so the read
   // data is sitting in the RAM output register for the whole RESP phase,
   // and a reset earlier in WAIT never reaches the array.
   assign ram_fire = (state_reg == ST_WAIT) && (cnt_reg == '0) && !err_reg;

   data_ram #(
      .DEPTH (MEM_DEPTH_WORDS)
   ) u_ram (
      .clk_i (clk_i),
      .re    (ram_fire && !write_reg),
      .we    (ram_fire && write_reg),
      .be    (store_be(f3_reg, addr_reg[1:0])),
      .addr  (addr_reg[IDX_W+1:2]),
      .wdata (store_data(f3_reg, wdata_reg)),
      .rdata (ram_q)
   );

   assign req_ready_o = (state_reg == ST_IDLE);
   assign rsp_valid_o = (state_reg == ST_RESP);
   assign rsp_err_o   = rsp_valid_o && err_reg;
   // Gated by state so rdata reads 0 straight out of reset even though
   // the RAM output register itself is not reset.
   assign rsp_rdata_o = (rsp_valid_o && !write_reg && !err_reg) ?
                        load_extend(ram_q, f3_reg, addr_reg[1:0]) : 32'd0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl -- directed self-checking bench for data_mem_ctrl
// (WAIT_STATES=3, 16-word memory so address wrap is easy to reach).
module tb_data_mem_ctrl;

   localparam int WS    = 3;
   localparam int DEPTH = 16;

   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010;
   localparam logic [2:0] LBU = 3'b100, LHU = 3'b101;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_write_i;
   logic [2:0]  req_funct3_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;

   int n_tests = 0;
   int n_fail  = 0;

   data_mem_ctrl #(
      .ADDR_WIDTH      (32),
      .MEM_DEPTH_WORDS (DEPTH),
      .WAIT_STATES     (WS)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_write_i  (req_write_i),
      .req_funct3_i (req_funct3_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_rdata_o  (rsp_rdata_o),
      .rsp_err_o    (rsp_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   // One full transaction. During the optional stall the core keeps
   // rsp_ready_i low and pushes a rogue SW 0x30 that must be ignored.
   task automatic access(input string tag, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_r, input logic exp_e, input int stall);
      int lat;
      @(negedge clk_i);
      check({tag, ".req_ready"}, 32'(req_ready_o), 32'd1);
      req_valid_i  = 1'b1;
      req_write_i  = w;
      req_funct3_i = f3;
      req_addr_i   = a;
      req_wdata_i  = d;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      lat = 0;
      while (!rsp_valid_o && lat < 20) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      check({tag, ".latency"}, 32'(lat), 32'(WS));
      check({tag, ".rdata"}, rsp_rdata_o, exp_r);
      check({tag, ".err"}, 32'(rsp_err_o), 32'(exp_e));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk_i);
         req_valid_i  = 1'b1;
         req_write_i  = 1'b1;
         req_funct3_i = LW;
         req_addr_i   = 32'h30;
         req_wdata_i  = 32'hFFFF_FFFF;
         @(posedge clk_i);
         #1;
         check({tag, ".stall_valid"}, 32'(rsp_valid_o), 32'd1);
         check({tag, ".stall_rdata"}, rsp_rdata_o, exp_r);
         check({tag, ".stall_ready"}, 32'(req_ready_o), 32'd0);
      end
      @(negedge clk_i);
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      rsp_ready_i = 1'b0;
      check({tag, ".rsp_done"}, 32'(rsp_valid_o), 32'd0);
      check({tag, ".idle_ready"}, 32'(req_ready_o), 32'd1);
      $display("[TB] %s w=%0d f3=%03b addr=%08h wdata=%08h -> exp rdata=%08h err=%0d lat=%0d",
               tag, w, f3, a, d, exp_r, exp_e, lat);
   endtask

   initial begin
      rst_i        = 1'b1;
      req_valid_i  = 1'b0;
      req_write_i  = 1'b0;
      req_funct3_i = 3'd0;
      req_addr_i   = 32'd0;
      req_wdata_i  = 32'd0;
      rsp_ready_i  = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check("reset.req_ready", 32'(req_ready_o), 32'd1);
      check("reset.rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("reset.rsp_rdata", rsp_rdata_o, 32'd0);
      check("reset.rsp_err", 32'(rsp_err_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // word store / load round trip
      access("sw_10",  1'b1, LW, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 0);
      access("lw_10",  1'b0, LW, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);

      // byte store into a cleared word, then every load flavour
      access("sw0_10", 1'b1, LW, 32'h10, 32'h0, 32'd0, 1'b0, 0);
      access("sb_13",  1'b1, LB, 32'h13, 32'h80, 32'd0, 1'b0, 0);
      access("lb_13",  1'b0, LB, 32'h13, 32'd0, 32'hFFFF_FF80, 1'b0, 0);
      access("lbu_13", 1'b0, LBU, 32'h13, 32'd0, 32'h0000_0080, 1'b0, 0);
      access("lw_10b", 1'b0, LW, 32'h10, 32'd0, 32'h8000_0000, 1'b0, 0);
      access("lh_12",  1'b0, LH, 32'h12, 32'd0, 32'hFFFF_8000, 1'b0, 0);
      access("lhu_12", 1'b0, LHU, 32'h12, 32'd0, 32'h0000_8000, 1'b0, 0);

      // response back-pressure with a rogue request that must be ignored
      access("sw0_30", 1'b1, LW, 32'h30, 32'h0, 32'd0, 1'b0, 0);
      access("lw_stall", 1'b0, LW, 32'h10, 32'd0, 32'h8000_0000, 1'b0, 5);
      access("lw_30",  1'b0, LW, 32'h30, 32'd0, 32'h0, 1'b0, 0);

      // reset in the middle of WAIT drops an uncommitted store
      access("sw0_20", 1'b1, LW, 32'h20, 32'h0, 32'd0, 1'b0, 0);
      @(negedge clk_i);
      req_valid_i  = 1'b1;
      req_write_i  = 1'b1;
      req_funct3_i = LW;
      req_addr_i   = 32'h20;
      req_wdata_i  = 32'h1234_5678;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      @(posedge clk_i);
      #2;
      rst_i = 1'b1;
      #1;
      check("midrst.rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("midrst.req_ready", 32'(req_ready_o), 32'd1);
      check("midrst.rsp_rdata", rsp_rdata_o, 32'd0);
      check("midrst.rsp_err", 32'(rsp_err_o), 32'd0);
      $display("[TB] midrst SW 0x20 12345678 aborted by reset in WAIT");
      @(negedge clk_i);
      rst_i = 1'b0;
      access("lw_20",  1'b0, LW, 32'h20, 32'd0, 32'h0, 1'b0, 0);
      access("lw_keep", 1'b0, LW, 32'h10, 32'd0, 32'h8000_0000, 1'b0, 0);

      // misaligned halfword / word
      access("sw_20",  1'b1, LW, 32'h20, 32'h1234_8001, 32'd0, 1'b0, 0);
`ifdef MISALIGN_CHECK_EN
      access("lh_21",  1'b0, LH, 32'h21, 32'd0, 32'h0, 1'b1, 0);
      access("lw_22",  1'b0, LW, 32'h22, 32'd0, 32'h0, 1'b1, 0);
      access("sw_22",  1'b1, LW, 32'h22, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
      access("lw_20c", 1'b0, LW, 32'h20, 32'd0, 32'h1234_8001, 1'b0, 0);
`else
      access("lh_21",  1'b0, LH, 32'h21, 32'd0, 32'hFFFF_8001, 1'b0, 0);
      access("lw_22",  1'b0, LW, 32'h22, 32'd0, 32'h1234_8001, 1'b0, 0);
`endif

      // illegal funct3 and address wrap
      access("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'd0, 32'h0, 1'b1, 0);
      access("sw_wrap",   1'b1, LW, 32'(4*DEPTH+8), 32'hCAFE_F00D, 32'd0, 1'b0, 0);
      access("lw_08",     1'b0, LW, 32'h08, 32'd0, 32'hCAFE_F00D, 1'b0, 0);
      access("st_f3_100", 1'b1, 3'b100, 32'h08, 32'h0, 32'd0, 1'b1, 0);
      access("lw_08b",    1'b0, LW, 32'h08, 32'd0, 32'hCAFE_F00D, 1'b0, 0);
      access("sh_0a",     1'b1, LH, 32'h0A, 32'h0000_BEEF, 32'd0, 1'b0, 0);
      access("lw_08c",    1'b0, LW, 32'h08, 32'd0, 32'hBEEF_F00D, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
